// File: rtl/gray_ptr_sync.sv
// Multi-stage synchronizer for Gray-coded FIFO pointers with binary conversion and movement reporting.
// Optional Gray-violation checker is built when GRAY_PTR_SYNC_CHECK_EN is defined.
module gray_ptr_sync #(
    parameter int NUM_BITS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                w_clk,
    input  logic                w_rst,
    input  logic [NUM_BITS-1:0] ptr_gray_async,
    input  logic                clr_err,
    output logic [NUM_BITS-1:0] ptr_gray_sync,
    output logic [NUM_BITS-1:0] ptr_bin_sync,
    output logic                ptr_changed,
    output logic [NUM_BITS-1:0] ptr_delta,
    output logic                sync_valid,
    output logic                gray_err
);

    localparam int              CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_STAGES + 1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || NUM_BITS < 2) begin : g_bad_param
            $error("gray_ptr_sync: SYNC_STAGES must be 2..4 and NUM_BITS >= 2");
        end
    endgenerate

    logic [NUM_BITS-1:0] sync_chain [SYNC_STAGES];
    logic [NUM_BITS-1:0] bin_next;
    logic [CNT_W-1:0]    warm_cnt;

    // Pure flop chain: nothing may sit between stages or metastability margin is lost.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= '0;
            end
        end else begin
            sync_chain[0] <= ptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
        end
    end

    assign ptr_gray_sync = sync_chain[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_next = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            bin_next[i] = ^(ptr_gray_sync >> i);
        end
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            warm_cnt   <= '0;
            sync_valid <= 1'b0;
        end else begin
            if (warm_cnt != CNT_MAX) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
            sync_valid <= (warm_cnt == CNT_MAX);
        end
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            ptr_bin_sync <= '0;
            ptr_changed  <= 1'b0;
            ptr_delta    <= '0;
        end else begin
            ptr_bin_sync <= bin_next;
            ptr_changed  <= sync_valid & (bin_next != ptr_bin_sync);
            ptr_delta    <= sync_valid ? (bin_next - ptr_bin_sync) : '0;
        end
    end

`ifdef GRAY_PTR_SYNC_CHECK_EN
    logic [NUM_BITS-1:0] gray_prev;
    logic                violation;

    always_comb begin
        violation = sync_valid && ($countones(ptr_gray_sync ^ gray_prev) > 1);
    end

    // A violation in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            gray_prev <= '0;
            gray_err  <= 1'b0;
        end else begin
            gray_prev <= ptr_gray_sync;
            if (violation) begin
                gray_err <= 1'b1;
            end else if (clr_err) begin
                gray_err <= 1'b0;
            end
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign gray_err       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: directed plus random Gray pointer streams into 2-stage and 4-stage instances,
// compared against an edge-indexed history model.
module tb_gray_ptr_sync;
  localparam int N = 4;

  logic         w_clk;
  logic         w_rst;
  logic [N-1:0] ptr_gray_async;
  logic         clr_err;

  logic [N-1:0] s2_gray, s2_bin, s2_delta;
  logic         s2_chg, s2_valid, s2_err;
  logic [N-1:0] s4_gray, s4_bin, s4_delta;
  logic         s4_chg, s4_valid, s4_err;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  logic [N-1:0] exp_q[$];
  bit err2 = 0;
  bit err4 = 0;
  int b_cur = 0;

  gray_ptr_sync #(.NUM_BITS(N), .SYNC_STAGES(2)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .ptr_gray_async(ptr_gray_async), .clr_err(clr_err),
    .ptr_gray_sync(s2_gray), .ptr_bin_sync(s2_bin), .ptr_changed(s2_chg),
    .ptr_delta(s2_delta), .sync_valid(s2_valid), .gray_err(s2_err)
  );

  gray_ptr_sync #(.NUM_BITS(N), .SYNC_STAGES(4)) dut4 (
    .w_clk(w_clk), .w_rst(w_rst), .ptr_gray_async(ptr_gray_async), .clr_err(clr_err),
    .ptr_gray_sync(s4_gray), .ptr_bin_sync(s4_bin), .ptr_changed(s4_chg),
    .ptr_delta(s4_delta), .sync_valid(s4_valid), .gray_err(s4_err)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  function automatic logic [N-1:0] b2g(input int b);
    logic [N-1:0] v;
    v = N'(b);
    return v ^ (v >> 1);
  endfunction

  // Inverse of the Gray definition found by search, independent of any XOR-chain formulation.
  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    for (int v = 0; v < (1 << N); v++) begin
      if (b2g(v) == g) return N'(v);
    end
    return '0;
  endfunction

  // Synchronized Gray value after edge tt: the input sampled s-1 edges earlier.
  function automatic logic [N-1:0] gs(input int s, input int tt);
    int k;
    k = tt - s + 1;
    if (k >= 1 && k <= exp_q.size()) return exp_q[k-1];
    return '0;
  endfunction

  function automatic logic [N-1:0] bs(input int s, input int tt);
    return g2b(gs(s, tt - 1));
  endfunction

  function automatic bit vld(input int s, input int tt);
    return tt >= s + 2;
  endfunction

  function automatic bit viol(input int s, input int tt);
    return vld(s, tt - 1) && ($countones(gs(s, tt - 1) ^ gs(s, tt - 2)) > 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp_v);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] d2, d4;
    d2 = vld(2, t - 1) ? N'(bs(2, t) - bs(2, t - 1)) : '0;
    d4 = vld(4, t - 1) ? N'(bs(4, t) - bs(4, t - 1)) : '0;
    check("s2_gray",  32'(s2_gray),  32'(gs(2, t)));
    check("s2_bin",   32'(s2_bin),   32'(bs(2, t)));
    check("s2_valid", 32'(s2_valid), 32'(vld(2, t)));
    check("s2_chg",   32'(s2_chg),   32'(vld(2, t - 1) && (bs(2, t) != bs(2, t - 1))));
    check("s2_delta", 32'(s2_delta), 32'(d2));
    check("s2_err",   32'(s2_err),   32'(err2));
    check("s4_gray",  32'(s4_gray),  32'(gs(4, t)));
    check("s4_bin",   32'(s4_bin),   32'(bs(4, t)));
    check("s4_valid", 32'(s4_valid), 32'(vld(4, t)));
    check("s4_chg",   32'(s4_chg),   32'(vld(4, t - 1) && (bs(4, t) != bs(4, t - 1))));
    check("s4_delta", 32'(s4_delta), 32'(d4));
    check("s4_err",   32'(s4_err),   32'(err4));
  endtask

  // Drive one input/clr pair for one edge, advance the model, check on the falling edge.
  task automatic step(input logic [N-1:0] g, input bit c);
    ptr_gray_async = g;
    clr_err        = c;
    @(posedge w_clk);
    t++;
    exp_q.push_back(g);
`ifdef GRAY_PTR_SYNC_CHECK_EN
    err2 = viol(2, t) ? 1'b1 : (c ? 1'b0 : err2);
    err4 = viol(4, t) ? 1'b1 : (c ? 1'b0 : err4);
`endif
    @(negedge w_clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gray2"},  32'(s2_gray),  0);
    check({tag, "_bin2"},   32'(s2_bin),   0);
    check({tag, "_chg2"},   32'(s2_chg),   0);
    check({tag, "_delta2"}, 32'(s2_delta), 0);
    check({tag, "_valid2"}, 32'(s2_valid), 0);
    check({tag, "_err2"},   32'(s2_err),   0);
    check({tag, "_bin4"},   32'(s4_bin),   0);
    check({tag, "_valid4"}, 32'(s4_valid), 0);
  endtask

  task automatic release_reset();
    @(negedge w_clk);
    w_rst = 1'b1;
    exp_q.delete();
    t    = 0;
    err2 = 0;
    err4 = 0;
  endtask

  task automatic walk_to(input int b_target);
    while (b_cur != b_target) begin
      b_cur = (b_cur + 1) % (1 << N);
      step(b2g(b_cur), 1'b0);
    end
  endtask

  task automatic hold(input int n, input bit c);
    for (int i = 0; i < n; i++) step(b2g(b_cur), c);
  endtask

  initial begin
    // Clock/reset
    w_rst          = 1'b0;
    ptr_gray_async = '0;
    clr_err        = 1'b0;
    #1;
    check_zero("rst0");
    release_reset();

    // Warm-up with input held at zero
    hold(7, 1'b0);
    check("s2_valid_edge7", 32'(s2_valid), 1);

    // Single-step Gray sequence 0000->0001->0011->0010
    b_cur = 1; step(4'b0001, 1'b0);
    b_cur = 2; step(4'b0011, 1'b0);
    b_cur = 3; step(4'b0010, 1'b0);
    hold(6, 1'b0);

    // Wrap-around 14 -> 15 -> 0
    walk_to(14);
    walk_to(15);
    walk_to(0);
    hold(6, 1'b0);
    check("wrap_bin", 32'(s2_bin), 0);

    // Mid-stream asynchronous reset at binary 7
    walk_to(7);
    hold(6, 1'b0);
    check("pre_rst_bin", 32'(s2_bin), 7);
    #2 w_rst = 1'b0;
    #1;
    check_zero("rst_mid");
    release_reset();
    b_cur = 0;
    hold(8, 1'b0);
    walk_to(3);
    walk_to(0);
    hold(4, 1'b0);

    // Illegal jump 0000 -> 0011, clear, then jump again with clr held
    b_cur = 2;
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    check("jump_delta", 32'(s2_delta), 2);
`ifdef GRAY_PTR_SYNC_CHECK_EN
    check("jump_err", 32'(s2_err), 1);
`endif
    hold(2, 1'b0);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b0);
    check("clr_err_done", 32'(s2_err), 0);
    b_cur = 0;
    hold(6, 1'b1);
    b_cur = 2;
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);
`ifdef GRAY_PTR_SYNC_CHECK_EN
    check("set_wins", 32'(s2_err), 1);
`endif
    hold(4, 1'b0);

    // Randomized walk: mostly legal single steps, some holds, occasional illegal jumps
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60) b_cur = (b_cur + 1) % (1 << N);
      else if (r >= 85) b_cur = $urandom_range(0, (1 << N) - 1);
      step(b2g(b_cur), ($urandom_range(0, 9) == 0));
    end

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
